// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator block.
package mac_pkg;

    localparam int PROD_W_D = 32;
    localparam int ACC_W_D  = 40;
    localparam int LEN_W_D  = 8;
    localparam int OUT_W_D  = 32;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / result-out valid-ready bundle for the MAC accumulator.
interface mac_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 32
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport master (
        output prod_valid, prod_data, out_ready,
        input  prod_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  prod_valid, prod_data, out_ready,
        output prod_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_saturate.sv
// Combinational signed clip from ACC_W to OUT_W bits.
module mac_saturate #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 32
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);
    localparam logic [OUT_W-1:0] LP_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] LP_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [ACC_W-OUT_W:0] w_hi;
    logic                 w_fit;

    // Value fits when all bits above the output sign bit copy it
    assign w_hi   = i_acc[ACC_W-1:OUT_W-1];
    assign w_fit  = (&w_hi) | ~(|w_hi);
    assign o_sat  = ~w_fit;
    assign o_data = w_fit         ? i_acc[OUT_W-1:0] :
                    i_acc[ACC_W-1] ? LP_MIN : LP_MAX;
endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed block of signed products and emits a saturated result.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int LEN_W  = LEN_W_D,
    parameter int OUT_W  = OUT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             ovf,
    mac_accumulator_if.slave bus
);
    mac_state_t       r_state;
    mac_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [OUT_W-1:0] r_data;
    logic             r_sat;
    logic             r_ovf;

    logic             w_start;
    logic             w_xfer;
    logic             w_last;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [OUT_W-1:0] w_sat_data;
    logic             w_sat_flag;

    assign w_start   = (r_state == IDLE) && start;
    assign w_xfer    = (r_state == ACCUM) && bus.prod_valid;
    assign w_last    = (r_cnt == r_len - 1'b1);
    assign w_acc_nxt = r_acc +
        {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};

    mac_saturate #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_acc  (w_acc_nxt),
        .o_data (w_sat_data),
        .o_sat  (w_sat_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start)
                    w_state_nxt = (len == '0) ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (w_xfer && w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_sat  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_start) begin
            r_len <= len;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (len == '0) begin
                r_data <= '0;
                r_sat  <= 1'b0;
            end
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_data <= w_sat_data;
                r_sat  <= w_sat_flag;
                if (w_sat_flag) r_ovf <= 1'b1;
            end
        end
    end

    assign busy           = (r_state != IDLE);
    assign ovf            = r_ovf;
    assign bus.prod_ready = (r_state == ACCUM);
    assign bus.out_valid  = (r_state == HOLD);
    assign bus.out_data   = r_data;
    assign bus.out_sat    = r_sat;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with hand-computed expectations.
module tb_mac_accumulator;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       ovf;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [31:0] held;

    mac_accumulator_if #(.PROD_W(32), .OUT_W(32)) bus ();

    mac_accumulator dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .ovf   (ovf),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_prdy"}, 64'(bus.prod_ready), 64'd0);
        chk({tag, "_oval"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic begin_block(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send(input logic [31:0] d);
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        tick();
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        len            = 8'd0;
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.out_ready  = 1'b1;
        #1;
        chk_idle("rst");
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_sat", 64'(bus.out_sat), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Block 1: 100 - 50 + 7
        begin_block(8'd3);
        chk("b1_busy", 64'(busy), 64'd1);
        chk("b1_prdy", 64'(bus.prod_ready), 64'd1);
        send(32'd100);
        send(-32'sd50);
        chk("b1_noval", 64'(bus.out_valid), 64'd0);
        send(32'd7);
        chk("b1_oval", 64'(bus.out_valid), 64'd1);
        chk("b1_data", 64'(bus.out_data), 64'd57);
        chk("b1_sat", 64'(bus.out_sat), 64'd0);
        chk("b1_ovf", 64'(ovf), 64'd0);
        chk("b1_prdy0", 64'(bus.prod_ready), 64'd0);
        tick();
        chk_idle("b1_done");

        // Block 2: 4 * 2^30 clips high
        begin_block(8'd4);
        repeat (4) send(32'h4000_0000);
        chk("b2_oval", 64'(bus.out_valid), 64'd1);
        chk("b2_data", 64'(bus.out_data), 64'(SAT_MAX));
        chk("b2_sat", 64'(bus.out_sat), 64'd1);
        chk("b2_ovf", 64'(ovf), 64'd1);
        tick();
        chk("b2_ovf_idle", 64'(ovf), 64'd1);

        // Block 3: 3 * -2^30 clips low; start clears ovf
        begin_block(8'd3);
        chk("b3_ovf_clr", 64'(ovf), 64'd0);
        repeat (3) send(32'hC000_0000);
        chk("b3_data", 64'(bus.out_data), 64'(SAT_MIN));
        chk("b3_sat", 64'(bus.out_sat), 64'd1);
        chk("b3_ovf", 64'(ovf), 64'd1);
        tick();

        // Block 4: gaps on input, backpressure on output
        bus.out_ready = 1'b0;
        begin_block(8'd2);
        repeat (3) begin
            chk("b4_gap_prdy", 64'(bus.prod_ready), 64'd1);
            tick();
        end
        send(32'd1000);
        repeat (3) begin
            chk("b4_gap_oval", 64'(bus.out_valid), 64'd0);
            tick();
        end
        send(-32'sd3000);
        held = bus.out_data;
        chk("b4_data", 64'(bus.out_data), 64'hFFFF_F830);
        for (int i = 0; i < 5; i++) begin
            chk("b4_hold_oval", 64'(bus.out_valid), 64'd1);
            chk("b4_hold_prdy", 64'(bus.prod_ready), 64'd0);
            chk("b4_hold_data", 64'(bus.out_data), 64'(held));
            if (i == 2) begin
                start          = 1'b1;
                len            = 8'd9;
                bus.prod_valid = 1'b1;
                bus.prod_data  = 32'd77;
            end
            tick();
            start          = 1'b0;
            len            = 8'd0;
            bus.prod_valid = 1'b0;
            bus.prod_data  = '0;
        end
        chk("b4_hold_end", 64'(bus.out_valid), 64'd1);
        chk("b4_final", 64'(bus.out_data), 64'hFFFF_F830);
        chk("b4_sat", 64'(bus.out_sat), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk_idle("b4_rel");
        tick();
        chk_idle("b4_nostart");

        // Block 5: asynchronous reset mid-block
        begin_block(8'd4);
        send(32'd11);
        send(32'd22);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("b5_rst");
        chk("b5_rst_data", 64'(bus.out_data), 64'd0);
        chk("b5_rst_ovf", 64'(ovf), 64'd0);
        tick();
        rst = 1'b0;
        chk_idle("b5_after");
        begin_block(8'd1);
        send(32'd5);
        chk("b5_oval", 64'(bus.out_valid), 64'd1);
        chk("b5_data", 64'(bus.out_data), 64'd5);
        tick();

        // Block 6: zero-length block
        bus.prod_valid = 1'b1;
        bus.prod_data  = 32'd123;
        begin_block(8'd0);
        chk("b6_oval", 64'(bus.out_valid), 64'd1);
        chk("b6_data", 64'(bus.out_data), 64'd0);
        chk("b6_sat", 64'(bus.out_sat), 64'd0);
        chk("b6_prdy", 64'(bus.prod_ready), 64'd0);
        bus.prod_valid = 1'b0;
        tick();
        chk_idle("b6_done");
        chk("b6_data_idle", 64'(bus.out_data), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 16x16 signed Booth multiplier. Accepts a stream of 32-bit signed products over a valid/ready handshake and sums a programmed block of `len` products into a 40-bit accumulator. It then presents the sum, saturated to 32 bits, on a registered valid/ready output. It turns per-cycle products into dot-product / FIR-tap results for the next stage.

## Interface
Parameters:
- `PROD_W`, 32, product input width (signed, two's complement)
- `ACC_W`, 40, internal accumulator width; must satisfy `ACC_W >= PROD_W + LEN_W`
- `LEN_W`, 8, width of block-length field
- `OUT_W`, 32, result width after saturation

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a block; sampled only in IDLE.
- `len` in LEN_W: number of products in the block; sampled with `start`.
- `busy` out 1: high in ACCUM and HOLD.
- `prod_valid` in 1: product available.
- `prod_ready` out 1: block accepts product.
- `prod_data` in PROD_W: signed product.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts result.
- `out_data` out OUT_W: saturated signed sum.
- `out_sat` out 1: `out_data` was clipped; qualified by `out_valid`.
- `ovf` out 1: sticky saturation flag; cleared by `rst` or an accepted `start`.

## Operation
- FSM states: IDLE, ACCUM, HOLD. Encoding comes from the package enum.
- IDLE:
  - `prod_ready`=0, `out_valid`=0.
  - On `start`: latch `len`, clear accumulator and count, clear `ovf`.
  - If `len`≠0, go to ACCUM.
  - If `len`=0, go to HOLD with `out_data`=0 and `out_sat`=0.
- ACCUM:
  - `prod_ready`=1, decoded from state only.
  - On each transfer (`prod_valid && prod_ready`): acc += sign-extended `prod_data`; count++.
  - On the transfer where count = len−1, register the saturated result and go to HOLD.
  - `prod_valid` gaps are allowed; the accumulator holds.
- HOLD:
  - `out_valid`=1. `out_data` and `out_sat` are stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
  - `prod_ready`=0.
- Saturation, applied to the final ACC_W sum:
  - If acc > 2^31−1: `out_data`=0x7FFFFFFF.
  - If acc < −2^31: `out_data`=0x80000000.
  - Otherwise, `out_data`=acc[31:0].
  - Any clip sets `out_sat` and `ovf`.
- The accumulator never wraps for len ≤ 255 at ACC_W=40.
- `start` outside IDLE is ignored and `len` is not re-sampled.

## Timing
- Reset values: state=IDLE; all outputs 0, including `busy`, `prod_ready`, `out_valid`, `out_data`, `out_sat` and `ovf`. The accumulator and count are also 0.
- `start` at edge k: `busy`=1 and `prod_ready`=1 from cycle k+1.
- Last product transferred at edge n: `out_valid`=1 in cycle n+1. Latency from last product to result is 1 cycle.
- `len`=0: `out_valid`=1 one cycle after `start`.
- HOLD to IDLE: on the edge where `out_ready`=1. A new `start` is accepted at the earliest on the following edge, so there is one idle cycle between blocks.
- Reset mid-operation: takes effect immediately (asynchronous). In-flight products and the pending result are discarded. No output glitches to a non-reset value.

## Structure
- Package `mac_pkg` holds:
  - State enum `mac_state_t` (IDLE, ACCUM, HOLD)
  - Default width constants
  - `SAT_MAX` = 32'h7FFF_FFFF
  - `SAT_MIN` = 32'h8000_0000
- Sub-module `mac_saturate`: combinational ACC_W→OUT_W clip producing data and a sat flag. The top level instantiates it in front of the output register.
- The top level holds the FSM, count, accumulator and output registers.

## Test plan
- len=3, products 100, −50, 7, `out_ready`=1 → `out_data`=57, `out_sat`=0, `ovf`=0; `out_valid` one cycle after the 3rd transfer.
- len=4, four products of 0x40000000 → `out_data`=0x7FFFFFFF, `out_sat`=1, `ovf`=1. Then a new `start` clears `ovf`.
- len=3, three products of 0xC0000000 (−2^30) → `out_data`=0x80000000, `out_sat`=1.
- len=2, with `prod_valid` gaps of 3 cycles and `out_ready` held low for 5 cycles in HOLD:
  - `out_data` is stable.
  - `prod_ready`=0.
  - A `start` pulse in HOLD is ignored.
  - Result is correct on release.
- `rst` asserted after 2 of 4 products → all outputs 0 immediately. Then len=1 with product 5 → `out_data`=5.
- len=0 → `out_valid` in the cycle after `start`, `out_data`=0, no product accepted.
